fifo_rd_stream: RTL

Read-side drain stage for the 8-bit synchronous FIFO. It issues `rd` strobes against the FIFO's `empty` flag and captures `data_out`, which the FIFO returns one cycle after an accepted read. It then presents the words as a valid/ready stream to the downstream consumer. A 2-entry skid buffer lets the block sustain one word per cycle under continuous `m_ready` without ever losing a word already in flight from the FIFO.

---
 rtl/fifo_rd_stream_pkg.sv | 23 ++
 rtl/fifo_rd_skid.sv | 108 ++++++++++
 rtl/fifo_rd_stream.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared definitions for the FIFO read-side drain stage: skid-buffer occupancy
// encoding, default data/counter widths and a small occupancy helper.
// -----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

  localparam int DW_DEFAULT    = 8;
  localparam int CNT_W_DEFAULT = 16;

  // Skid-buffer occupancy: number of words currently held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Occupancy as a plain count, so it can be added to the in-flight bit.
  function automatic logic [1:0] occ_count(input occ_e occ);
    return logic'(occ == TWO) ? 2'd2 : ((occ == ONE) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry skid buffer with push/pop and an occupancy state machine.
// The head entry is always the oldest word and drives the output directly.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   push       : write push_data to the tail this cycle
//   push_data  : word to write
//   pop        : remove the head word this cycle (ignored when empty)
//   occ        : registered occupancy (EMPTY/ONE/TWO)
//   head_data  : registered head word
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output occ_e          occ,
  output logic [DW-1:0] head_data
);

  occ_e          state_r;
  occ_e          state_s;
  logic [DW-1:0] head_r;
  logic [DW-1:0] head_s;
  logic [DW-1:0] tail_r;
  logic [DW-1:0] tail_s;

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next occupancy and next head/tail contents from (push, pop).
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    tail_s  = tail_r;
    case (state_r)
      EMPTY: begin
        if (push) begin
          state_s = ONE;
          head_s  = push_data;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Old head leaves, the captured word becomes the new head.
          state_s = ONE;
          head_s  = push_data;
        end else if (push) begin
          state_s = TWO;
          tail_s  = push_data;
        end else if (pop) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      TWO: begin
        if (pop) begin
          head_s = tail_r;
          if (push) begin
            state_s = TWO;
            tail_s  = push_data;
          end else begin
            state_s = ONE;
          end
        end else begin
          // Push without pop cannot occur here: the read issue logic never
          // owes a third word.
          state_s = TWO;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // Data storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= {DW{1'b0}};
      tail_r <= {DW{1'b0}};
    end else begin
      head_r <= head_s;
      tail_r <= tail_s;
    end
  end

  assign occ       = state_r;
  assign head_data = head_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain stage for the 8-bit synchronous FIFO. Issues rd strobes
// against empty, captures data_out one cycle after each accepted read into a
// 2-entry skid buffer and presents the words as a valid/ready stream.
//
// Optional feature macro: FIFO_RD_STREAM_CNT_EN adds the CNT_W parameter and
// the xfer_cnt port (wrapping count of completed output transfers).
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (shared with the FIFO)
//   en         : allows new reads; in-flight/buffered words drain regardless
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO data_out, valid the cycle after an accepted read
//   fifo_rd    : FIFO read strobe
//   m_valid    : output word available
//   m_data     : output word (skid-buffer head)
//   m_ready    : downstream accept
//   xfer_cnt   : completed transfers (only with FIFO_RD_STREAM_CNT_EN)
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DW = DW_DEFAULT
`ifdef FIFO_RD_STREAM_CNT_EN
  , parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_data,
  output logic             fifo_rd,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  input  logic             m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
  , output logic [CNT_W-1:0] xfer_cnt
`endif
);

  occ_e          occ_s;
  logic          inflight_r;
  logic          pop_s;
  logic [1:0]    slots_s;
  logic          rd_s;
  logic [DW-1:0] head_s;

  assign m_valid = (occ_s != EMPTY);
  assign m_data  = head_s;
  assign pop_s   = m_valid & m_ready;

  // Words buffered plus the one owed by last cycle's read; never exceeds 2.
  assign slots_s = occ_count(occ_s) + {1'b0, inflight_r};

  // Read issue: only when a slot is free now or is being freed by a pop.
  // Gated by rst so the strobe drops immediately on an asynchronous reset.
  always_comb begin
    rd_s = 1'b0;
    if (rst) begin
      rd_s = 1'b0;
    end else if (en && !fifo_empty) begin
      if (slots_s < 2'd2) begin
        rd_s = 1'b1;
      end else if (slots_s == 2'd2) begin
        rd_s = pop_s;
      end else begin
        rd_s = 1'b0;
      end
    end else begin
      rd_s = 1'b0;
    end
  end

  assign fifo_rd = rd_s;

  // Remember that the FIFO returns a word on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_s;
    end
  end

  fifo_rd_skid #(
    .DW (DW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (fifo_data),
    .pop       (pop_s),
    .occ       (occ_s),
    .head_data (head_s)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Completed-transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign xfer_cnt = cnt_r;
`endif

endmodule
